// File: rtl/mem_stage_pkg.sv
// Shared types and default widths for the MEM stage of the 24-bit pipeline.
package mem_stage_pkg;

    localparam int DATA_W_DEFAULT  = 24;
    localparam int DEST_W_DEFAULT  = 4;
    localparam int ADDR_W_DEFAULT  = 16;
    localparam int TIMEOUT_DEFAULT = 15;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_t;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-RAM request/ready bus between the MEM stage (master) and the RAM (slave).
interface mem_access_stage_if #(
    parameter int DATA_W = mem_stage_pkg::DATA_W_DEFAULT,
    parameter int ADDR_W = mem_stage_pkg::ADDR_W_DEFAULT
) ();

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );

endinterface

// File: rtl/mem_timeout_counter.sv
// Counts ACCESS cycles; expired is high in the TIMEOUT-th enabled cycle since clear.
module mem_timeout_counter #(
    parameter int TIMEOUT = mem_stage_pkg::TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count_r;

    assign expired = enable & (count_r == CNT_W'(TIMEOUT - 1));

    // Cycle counter: cleared on entry to ACCESS, saturates once expired.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (enable & ~expired) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: issues loads/stores over a req/ready bus and stalls upstream until done.
// Optional access watchdog enabled by defining MEM_ACCESS_TIMEOUT_EN.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DEST_W = DEST_W_DEFAULT,
`ifdef MEM_ACCESS_TIMEOUT_EN
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
`endif
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              writeback_enable_in,
    input  logic              mem_read_enable_in,
    input  logic              mem_write_enable_in,
    input  logic [DEST_W-1:0] instruction_dest_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] write_data_in,
    output logic              stall,
    mem_access_stage_if.master mem_bus,
    output logic              writeback_enable_out,
    output logic [DEST_W-1:0] instruction_dest_out,
    output logic [DATA_W-1:0] result_out,
    output logic              mem_error_out
);

    mem_state_t        state_r;
    logic              mem_op_s;
    logic              abort_s;
    logic              mem_req_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic              read_r;
    logic [DATA_W-1:0] alu_lat_r;
    logic [DEST_W-1:0] dest_lat_r;
    logic              wb_lat_r;
    logic              wb_out_r;
    logic [DEST_W-1:0] dest_out_r;
    logic [DATA_W-1:0] result_r;
    logic              error_r;

    assign mem_op_s = mem_read_enable_in | mem_write_enable_in;

`ifdef MEM_ACCESS_TIMEOUT_EN
    logic expired_s;

    mem_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   ((state_r == IDLE) & mem_op_s),
        .enable  (state_r == ACCESS),
        .expired (expired_s)
    );

    // A ready arriving in the expiry cycle still completes the access.
    assign abort_s = expired_s & ~mem_bus.mem_ready;
`else
    assign abort_s = 1'b0;
`endif

    // Upstream advances on the same edge the access completes or aborts.
    assign stall = mem_op_s & ~((state_r == ACCESS) & (mem_bus.mem_ready | abort_s));

    assign mem_bus.mem_req   = mem_req_r;
    assign mem_bus.mem_we    = mem_we_r;
    assign mem_bus.mem_addr  = mem_addr_r;
    assign mem_bus.mem_wdata = mem_wdata_r;

    assign writeback_enable_out = wb_out_r;
    assign instruction_dest_out = dest_out_r;
    assign result_out           = result_r;
    assign mem_error_out        = error_r;

    // IDLE/ACCESS sequencer with all bus and write-back outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            read_r      <= 1'b0;
            alu_lat_r   <= '0;
            dest_lat_r  <= '0;
            wb_lat_r    <= 1'b0;
            wb_out_r    <= 1'b0;
            dest_out_r  <= '0;
            result_r    <= '0;
            error_r     <= 1'b0;
        end else begin
            error_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (mem_op_s) begin
                        state_r     <= ACCESS;
                        mem_req_r   <= 1'b1;
                        mem_we_r    <= mem_write_enable_in;
                        mem_addr_r  <= alu_result_in[ADDR_W-1:0];
                        mem_wdata_r <= write_data_in;
                        read_r      <= mem_read_enable_in & ~mem_write_enable_in;
                        alu_lat_r   <= alu_result_in;
                        dest_lat_r  <= instruction_dest_in;
                        wb_lat_r    <= writeback_enable_in;
                        wb_out_r    <= 1'b0;
                    end else begin
                        wb_out_r   <= writeback_enable_in;
                        dest_out_r <= instruction_dest_in;
                        result_r   <= alu_result_in;
                    end
                end
                ACCESS: begin
                    if (mem_bus.mem_ready) begin
                        state_r    <= IDLE;
                        mem_req_r  <= 1'b0;
                        result_r   <= read_r ? mem_bus.mem_rdata : alu_lat_r;
                        dest_out_r <= dest_lat_r;
                        wb_out_r   <= wb_lat_r;
                    end else if (abort_s) begin
                        state_r   <= IDLE;
                        mem_req_r <= 1'b0;
                        wb_out_r  <= 1'b0;
                        error_r   <= 1'b1;
                    end else begin
                        wb_out_r <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    mem_req_r <= 1'b0;
                    wb_out_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: per-op timeline model checked every negedge.
module tb_mem_access_stage;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wb_in = 1'b0;
    logic        rd_in = 1'b0;
    logic        wr_in = 1'b0;
    logic [3:0]  dest_in = 4'd0;
    logic [23:0] alu_in = 24'd0;
    logic [23:0] wdata_in = 24'd0;
    logic        stall;
    logic        wb_out;
    logic [3:0]  dest_out;
    logic [23:0] result_out;
    logic        err_out;

    logic        exp_stall = 1'b0;
    logic        exp_req = 1'b0;
    logic        exp_we = 1'b0;
    logic [15:0] exp_addr = 16'd0;
    logic [23:0] exp_wdata = 24'd0;
    logic        exp_wb = 1'b0;
    logic [3:0]  exp_dest = 4'd0;
    logic [23:0] exp_result = 24'd0;
    logic        exp_err = 1'b0;

    int n_vec = 0;
    int n_fail = 0;

    mem_access_stage_if bus ();

    mem_access_stage dut (
        .clk                  (clk),
        .rst                  (rst),
        .writeback_enable_in  (wb_in),
        .mem_read_enable_in   (rd_in),
        .mem_write_enable_in  (wr_in),
        .instruction_dest_in  (dest_in),
        .alu_result_in        (alu_in),
        .write_data_in        (wdata_in),
        .stall                (stall),
        .mem_bus              (bus),
        .writeback_enable_out (wb_out),
        .instruction_dest_out (dest_out),
        .result_out           (result_out),
        .mem_error_out        (err_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare every cycle; dest/result only mean something when write-back is enabled.
    always @(negedge clk) begin
        check("stall", 32'(stall), 32'(exp_stall));
        check("mem_req", 32'(bus.mem_req), 32'(exp_req));
        check("mem_we", 32'(bus.mem_we), 32'(exp_we));
        check("mem_addr", 32'(bus.mem_addr), 32'(exp_addr));
        check("mem_wdata", 32'(bus.mem_wdata), 32'(exp_wdata));
        check("wb_out", 32'(wb_out), 32'(exp_wb));
        check("err_out", 32'(err_out), 32'(exp_err));
        if (exp_wb) begin
            check("dest_out", 32'(dest_out), 32'(exp_dest));
            check("result_out", 32'(result_out), 32'(exp_result));
        end
    end

    // One instruction; n_ready = ACCESS cycles until ready, 0 = ready never comes.
    task automatic do_op(input logic wb, input logic rd, input logic wr, input logic [3:0] dest,
                         input logic [23:0] alu, input logic [23:0] wd, input int n_ready,
                         input logic [23:0] rdata);
        logic is_mem;
        int   limit;
        is_mem = rd | wr;
        wb_in = wb; rd_in = rd; wr_in = wr; dest_in = dest; alu_in = alu; wdata_in = wd;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 24'h5A5A5A;
        exp_stall = is_mem;
        @(posedge clk); #1;
        exp_err = 1'b0;
        if (!is_mem) begin
            exp_wb = wb; exp_dest = dest; exp_result = alu;
        end else begin
            exp_req = 1'b1; exp_we = wr; exp_addr = alu[15:0]; exp_wdata = wd; exp_wb = 1'b0;
            limit = (n_ready == 0) ? TIMEOUT : n_ready;
            for (int k = 1; k <= limit; k++) begin
                bus.mem_ready = (n_ready != 0) && (k == n_ready);
                bus.mem_rdata = rdata;
                exp_stall = (k != limit);
                @(posedge clk); #1;
            end
            exp_req = 1'b0;
            if (n_ready == 0) begin
                exp_wb = 1'b0; exp_err = 1'b1;
            end else begin
                exp_wb = wb; exp_dest = dest;
                exp_result = (rd && !wr) ? rdata : alu;
            end
        end
        wb_in = 1'b0; rd_in = 1'b0; wr_in = 1'b0; dest_in = 4'd0; alu_in = 24'd0; wdata_in = 24'd0;
        bus.mem_ready = 1'b0;
        exp_stall = 1'b0;
    endtask

    initial begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 24'd0;
        #1;
        check("rst_req", 32'(bus.mem_req), 32'd0);
        check("rst_wb", 32'(wb_out), 32'd0);
        check("rst_result", 32'(result_out), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        do_op(1'b1, 1'b0, 1'b0, 4'd2, 24'd5, 24'd0, 0, 24'd0);
        check("nonmem_result", 32'(result_out), 32'd5);
        check("nonmem_dest", 32'(dest_out), 32'd2);

        do_op(1'b1, 1'b1, 1'b0, 4'd3, 24'd5, 24'd0, 3, 24'h00ABCD);
        check("load_result", 32'(result_out), 32'h00ABCD);
        check("load_wb", 32'(wb_out), 32'd1);

        do_op(1'b1, 1'b0, 1'b1, 4'd4, 24'd5, 24'd10, 1, 24'h123456);
        check("store_result", 32'(result_out), 32'd5);
        check("store_wdata", 32'(bus.mem_wdata), 32'd10);

        do_op(1'b1, 1'b1, 1'b0, 4'd9, 24'h12_0007, 24'd0, 1, 24'hC0FFEE);
        check("b2b_load_result", 32'(result_out), 32'hC0FFEE);

        do_op(1'b1, 1'b1, 1'b1, 4'd5, 24'd5, 24'd10, 2, 24'hFFFFFF);
        check("rdwr_result", 32'(result_out), 32'd5);
        check("rdwr_we", 32'(bus.mem_we), 32'd1);

        do_op(1'b0, 1'b0, 1'b0, 4'd6, 24'h000777, 24'd0, 0, 24'd0);

`ifdef MEM_ACCESS_TIMEOUT_EN
        do_op(1'b1, 1'b1, 1'b0, 4'd8, 24'h000021, 24'd0, 0, 24'h0000AA);
        check("timeout_err", 32'(err_out), 32'd1);
        check("timeout_wb", 32'(wb_out), 32'd0);
        do_op(1'b0, 1'b0, 1'b0, 4'd0, 24'd0, 24'd0, 0, 24'd0);
        check("timeout_err_pulse", 32'(err_out), 32'd0);
`else
        do_op(1'b1, 1'b1, 1'b0, 4'd8, 24'h000021, 24'd0, 21, 24'h0000AA);
        check("slow_load_result", 32'(result_out), 32'h0000AA);
        check("slow_load_err", 32'(err_out), 32'd0);
`endif

        // Reset in the middle of a load.
        wb_in = 1'b1; rd_in = 1'b1; dest_in = 4'd7; alu_in = 24'h000042;
        exp_stall = 1'b1;
        @(posedge clk); #1;
        exp_err = 1'b0; exp_req = 1'b1; exp_we = 1'b0; exp_addr = 16'h0042;
        exp_wdata = 24'd0; exp_wb = 1'b0;
        @(posedge clk); #1;
        #2;
        rst = 1'b0;
        wb_in = 1'b0; rd_in = 1'b0; dest_in = 4'd0; alu_in = 24'd0;
        exp_stall = 1'b0; exp_req = 1'b0; exp_addr = 16'd0; exp_dest = 4'd0; exp_result = 24'd0;
        #1;
        check("arst_req", 32'(bus.mem_req), 32'd0);
        check("arst_addr", 32'(bus.mem_addr), 32'd0);
        check("arst_result", 32'(result_out), 32'd0);
        check("arst_dest", 32'(dest_out), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        do_op(1'b0, 1'b0, 1'b0, 4'd0, 24'd0, 24'd0, 0, 24'd0);
        do_op(1'b0, 1'b0, 1'b0, 4'd0, 24'd0, 24'd0, 0, 24'd0);
        check("arst_no_wb", 32'(wb_out), 32'd0);

        do_op(1'b1, 1'b0, 1'b0, 4'd1, 24'h00BEEF, 24'd0, 0, 24'd0);
        check("recover_result", 32'(result_out), 32'h00BEEF);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
